// File: rtl/spi_buf_arb_if.sv
// spi_buf_arb_if: signal bundle between the SPI transmit-buffer arbiter, its two
// burst requesters and the CPU-side port of the 32-byte buffer.
//
// Requester side (index 0 and 1):
//   req, wr, addr[4:0], len[5:0], wdata[7:0]     requester -> arbiter
//   gnt, beat, rvalid, done                      arbiter -> requester
//   rdata[7:0]                                   arbiter -> requesters (shared)
// Buffer side:
//   buf_addr[7:0], buf_wr, buf_di[7:0]           arbiter -> buffer
//   buf_do[7:0]                                  buffer -> arbiter
//   spi_busy                                     SPI engine -> arbiter
//
// Modports: slave is the arbiter's view, master is the view of everything
// around it (requesters, buffer and SPI engine).
interface spi_buf_arb_if;
  // Requester 0
  logic       req0;
  logic       wr0;
  logic [4:0] addr0;
  logic [5:0] len0;
  logic [7:0] wdata0;
  logic       gnt0;
  logic       beat0;
  logic       rvalid0;
  logic       done0;
  // Requester 1
  logic       req1;
  logic       wr1;
  logic [4:0] addr1;
  logic [5:0] len1;
  logic [7:0] wdata1;
  logic       gnt1;
  logic       beat1;
  logic       rvalid1;
  logic       done1;
  // Shared read data
  logic [7:0] rdata;
  // Buffer port and SPI status
  logic       spi_busy;
  logic [7:0] buf_addr;
  logic       buf_wr;
  logic [7:0] buf_di;
  logic [7:0] buf_do;

  modport slave (
    input  req0, wr0, addr0, len0, wdata0,
    input  req1, wr1, addr1, len1, wdata1,
    input  spi_busy, buf_do,
    output gnt0, beat0, rvalid0, done0,
    output gnt1, beat1, rvalid1, done1,
    output rdata, buf_addr, buf_wr, buf_di
  );

  modport master (
    output req0, wr0, addr0, len0, wdata0,
    output req1, wr1, addr1, len1, wdata1,
    output spi_busy, buf_do,
    input  gnt0, beat0, rvalid0, done0,
    input  gnt1, beat1, rvalid1, done1,
    input  rdata, buf_addr, buf_wr, buf_di
  );
endinterface

// File: rtl/spi_buf_arb.sv
// spi_buf_arb: burst arbiter for the CPU-side port of the 32-byte SPI transmit
// buffer. Two requesters ask for read or write bursts; one burst is granted at a
// time and driven beat by beat onto the buffer port. Write bursts are not
// granted while the SPI side is transmitting; a write burst already granted
// runs to completion regardless of spi_busy.
//
// Ports:
//   clk     clock
//   reset   synchronous, active-high reset
//   bus     spi_buf_arb_if.slave: requester handshakes (req/wr/addr/len/wdata,
//           gnt/beat/rvalid/done), shared rdata, buffer port
//           (buf_addr/buf_wr/buf_di/buf_do) and spi_busy
//
// Per burst: request seen in IDLE (cycle 0), gnt pulse (cycle 1), beats on
// cycles 2..L+1, done pulse on cycle L+2, back in IDLE on cycle L+3. Burst
// length L = min(len, 32); L = 0 goes straight from GRANT to DONE.
//
// Configuration:
//   SPI_BUF_ARB_RR_EN defined   round-robin on ties (requester not served last
//                               wins; pointer updated at every grant)
//   undefined (default)         fixed priority, requester 0 wins ties
//
// All outputs are registered except buf_di, which follows the owner's wdata
// combinationally during write beats, and rdata, which passes the buffer's
// already-registered read port through while rvalid is high.
module spi_buf_arb (
  input  logic         clk,
  input  logic         reset,
  spi_buf_arb_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGrant = 2'd1;
  localparam logic [1:0] StBurst = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [5:0] MaxLen = 6'd32;

  // FSM and latched burst descriptor
  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;   // requester index that owns the burst
  logic       wr_q, wr_d;
  logic [4:0] addr_q, addr_d;     // address of the next beat to issue
  logic [5:0] len_q, len_d;       // effective (clipped) length
  logic [5:0] cnt_q, cnt_d;       // beats issued so far, including the live one

  // Registered outputs
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] beat_q, beat_d;
  logic [1:0] rvalid_q, rvalid_d;
  logic [1:0] done_q, done_d;
  logic [4:0] buf_addr_q, buf_addr_d;
  logic       buf_wr_q, buf_wr_d;

  // Arbitration
  logic       elig0, elig1;
  logic       win;
  logic [5:0] win_len;
  logic [5:0] win_len_eff;

  // A write request is only eligible while the SPI side is idle.
  assign elig0 = bus.req0 & (~bus.wr0 | ~bus.spi_busy);
  assign elig1 = bus.req1 & (~bus.wr1 | ~bus.spi_busy);

`ifdef SPI_BUF_ARB_RR_EN
  // Index of the requester served by the most recent grant.
  logic last_q, last_d;

  // On a tie, serve the one not served last; otherwise whoever is eligible.
  assign win = (elig0 & elig1) ? ~last_q : elig1;
`else
  // Requester 0 wins whenever it is eligible.
  assign win = ~elig0;
`endif

  assign win_len     = win ? bus.len1 : bus.len0;
  assign win_len_eff = (win_len > MaxLen) ? MaxLen : win_len;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    gnt_d      = 2'b00;
    beat_d     = 2'b00;
    rvalid_d   = 2'b00;
    done_d     = 2'b00;
    buf_wr_d   = 1'b0;
    buf_addr_d = buf_addr_q;
`ifdef SPI_BUF_ARB_RR_EN
    last_d     = last_q;
`endif

    // Buffer read data appears one cycle after each read beat.
    if (state_q == StBurst && !wr_q) begin
      rvalid_d[owner_q] = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (elig0 | elig1) begin
          state_d      = StGrant;
          owner_d      = win;
          wr_d         = win ? bus.wr1 : bus.wr0;
          addr_d       = win ? bus.addr1 : bus.addr0;
          len_d        = win_len_eff;
          gnt_d[win]   = 1'b1;
`ifdef SPI_BUF_ARB_RR_EN
          last_d       = win;
`endif
        end
      end

      StGrant: begin
        if (len_q == 6'd0) begin
          state_d          = StDone;
          done_d[owner_q]  = 1'b1;
        end else begin
          // Issue beat 0 on the next cycle.
          state_d          = StBurst;
          beat_d[owner_q]  = 1'b1;
          buf_wr_d         = wr_q;
          buf_addr_d       = addr_q;
          addr_d           = addr_q + 5'd1;
          cnt_d            = 6'd1;
        end
      end

      StBurst: begin
        if (cnt_q == len_q) begin
          // The live beat is the last one.
          state_d          = StDone;
          done_d[owner_q]  = 1'b1;
        end else begin
          beat_d[owner_q]  = 1'b1;
          buf_wr_d         = wr_q;
          buf_addr_d       = addr_q;
          addr_d           = addr_q + 5'd1;  // wraps 31 -> 0
          cnt_d            = cnt_q + 6'd1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 5'd0;
      len_q      <= 6'd0;
      cnt_q      <= 6'd0;
      gnt_q      <= 2'b00;
      beat_q     <= 2'b00;
      rvalid_q   <= 2'b00;
      done_q     <= 2'b00;
      buf_addr_q <= 5'd0;
      buf_wr_q   <= 1'b0;
`ifdef SPI_BUF_ARB_RR_EN
      // Treat requester 1 as last served so requester 0 wins the first tie.
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      beat_q     <= beat_d;
      rvalid_q   <= rvalid_d;
      done_q     <= done_d;
      buf_addr_q <= buf_addr_d;
      buf_wr_q   <= buf_wr_d;
`ifdef SPI_BUF_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  assign bus.gnt0     = gnt_q[0];
  assign bus.gnt1     = gnt_q[1];
  assign bus.beat0    = beat_q[0];
  assign bus.beat1    = beat_q[1];
  assign bus.rvalid0  = rvalid_q[0];
  assign bus.rvalid1  = rvalid_q[1];
  assign bus.done0    = done_q[0];
  assign bus.done1    = done_q[1];
  assign bus.buf_addr = {3'b000, buf_addr_q};
  assign bus.buf_wr   = buf_wr_q;

  // The owner presents its data in the beat cycle itself; zero otherwise.
  assign bus.buf_di = buf_wr_q ? (owner_q ? bus.wdata1 : bus.wdata0) : 8'h00;

  // buf_do is the buffer's registered read port; forward it while rvalid is up.
  assign bus.rdata = (|rvalid_q) ? bus.buf_do : 8'h00;

endmodule

// File: tb/tb_spi_buf_arb.sv
// Self-checking bench for spi_buf_arb. A transaction-level reference model
// predicts the winner of each arbitration round and the cycle-by-cycle outputs
// from the burst timing rules; a separate reference memory predicts read data.
`timescale 1ns/1ps
module tb_spi_buf_arb;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_buf_arb_if bus ();

  spi_buf_arb u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef SPI_BUF_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  // 32-byte buffer: synchronous write, one-cycle registered read.
  logic [7:0] bmem [32];
  always @(posedge clk) begin
    if (bus.buf_wr) bmem[bus.buf_addr[4:0]] <= bus.buf_di;
    bus.buf_do <= bmem[bus.buf_addr[4:0]];
  end

  // Reference state
  logic [7:0] ref_mem [32];
  logic [4:0] ref_addr;
  int         last_srv;
  int         n_checks;
  int         n_errors;

  // Pending request descriptors and per-requester write data
  bit         rq_req  [2];
  bit         rq_wr   [2];
  logic [4:0] rq_addr [2];
  logic [5:0] rq_len  [2];
  logic [7:0] wd [2][32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ctl_now();
    return {bus.gnt0, bus.gnt1, bus.beat0, bus.beat1, bus.rvalid0, bus.rvalid1,
            bus.done0, bus.done1, bus.buf_wr};
  endfunction

  // {sig0, sig1} pattern for requester w when the event is on.
  function automatic logic [1:0] sel2(input int w, input bit on);
    if (!on || w < 0) return 2'b00;
    return (w == 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic set_req(input int idx, input bit req, input bit wr, input int addr,
                         input int len);
    rq_req[idx]  = req;
    rq_wr[idx]   = wr;
    rq_addr[idx] = 5'(addr);
    rq_len[idx]  = 6'(len);
  endtask

  task automatic rand_wd(input int idx);
    for (int k = 0; k < 32; k++) wd[idx][k] = 8'($urandom);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " ctl"}, 32'(ctl_now()), 32'd0);
    check({tag, " addr"}, 32'(bus.buf_addr), 32'd0);
    check({tag, " rdata"}, 32'(bus.rdata), 32'd0);
    check({tag, " di"}, 32'(bus.buf_di), 32'd0);
  endtask

  // One arbitration round, entered at the start of an IDLE cycle (just after
  // the clock edge) and left at the start of the next IDLE cycle.
  // abort_at >= 2 asserts reset during that cycle of the burst.
  task automatic round(input bit busy, input bit mid_busy, input int abort_at);
    int         win;
    int         len_eff;
    int         last_c;
    logic [4:0] start;
    logic [4:0] ra;
    bit         e0, e1, wr, bt, rv;
    logic [8:0] exp_ctl;

    bus.req0 = rq_req[0]; bus.wr0 = rq_wr[0]; bus.addr0 = rq_addr[0]; bus.len0 = rq_len[0];
    bus.req1 = rq_req[1]; bus.wr1 = rq_wr[1]; bus.addr1 = rq_addr[1]; bus.len1 = rq_len[1];
    bus.spi_busy = busy;

    e0 = rq_req[0] && (!rq_wr[0] || !busy);
    e1 = rq_req[1] && (!rq_wr[1] || !busy);
    len_eff = 0;
    start = 5'd0;
    wr = 1'b0;
    if (!e0 && !e1) win = -1;
    else if (e0 && e1) win = (RrEn && last_srv == 0) ? 1 : 0;
    else win = e0 ? 0 : 1;

    if (win >= 0) begin
      last_srv = win;
      len_eff  = (int'(rq_len[win]) > 32) ? 32 : int'(rq_len[win]);
      start    = rq_addr[win];
      wr       = rq_wr[win];
      last_c   = len_eff + 2;
    end else begin
      last_c = 1;
    end

    for (int c = 0; c <= last_c; c++) begin
      if (c == 1) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      if (c == 2) bus.spi_busy = mid_busy;
      bus.wdata0 = 8'($urandom);
      bus.wdata1 = 8'($urandom);
      bt = (win >= 0) && c >= 2 && c <= len_eff + 1;
      rv = (win >= 0) && !wr && c >= 3 && c <= len_eff + 2;
      if (bt && wr) begin
        if (win == 0) bus.wdata0 = wd[0][c-2];
        else          bus.wdata1 = wd[1][c-2];
      end
      if (c == abort_at) reset = 1'b1;
      exp_ctl = {sel2(win, c == 1), sel2(win, bt), sel2(win, rv),
                 sel2(win, c == last_c && win >= 0), bt && wr};

      @(negedge clk);
      check($sformatf("ctl c%0d", c), 32'(ctl_now()), 32'(exp_ctl));
      if (bt) ref_addr = start + 5'(c - 2);
      check($sformatf("buf_addr c%0d", c), 32'(bus.buf_addr), 32'({3'b000, ref_addr}));
      if (bt && wr) begin
        check($sformatf("buf_di c%0d", c), 32'(bus.buf_di), 32'(wd[win][c-2]));
        ref_mem[ref_addr] = wd[win][c-2];
      end
      if (rv) begin
        ra = start + 5'(c - 3);
        check($sformatf("rdata c%0d", c), 32'(bus.rdata), 32'(ref_mem[ra]));
      end
      @(posedge clk);
      #1;

      if (c == abort_at) begin
        reset = 1'b0;
        last_srv = 1;
        ref_addr = 5'd0;
        @(negedge clk);
        check_quiet("abort+1");
        @(posedge clk);
        #1;
        @(negedge clk);
        check_quiet("abort+2");
        @(posedge clk);
        #1;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    last_srv = 1;
    ref_addr = 5'd0;
    for (int k = 0; k < 32; k++) ref_mem[k] = 8'h00;
    reset = 1'b1;
    bus.req0 = 1'b0; bus.wr0 = 1'b0; bus.addr0 = 5'd0; bus.len0 = 6'd0; bus.wdata0 = 8'd0;
    bus.req1 = 1'b0; bus.wr1 = 1'b0; bus.addr1 = 5'd0; bus.len1 = 6'd0; bus.wdata1 = 8'd0;
    bus.spi_busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Write 0xA0..0xA3 at address 3
    set_req(0, 1, 1, 3, 4);
    set_req(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) wd[0][k] = 8'hA0 + 8'(k);
    round(1'b0, 1'b0, -1);

    // Fill the whole buffer: len 40 clips to 32 and wraps back to address 7
    rand_wd(0);
    set_req(0, 1, 1, 7, 40);
    round(1'b0, 1'b0, -1);

    // Read across the wrap point
    set_req(0, 0, 0, 0, 0);
    set_req(1, 1, 0, 30, 4);
    round(1'b0, 1'b0, -1);

    // Simultaneous single-byte reads
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1, 0, int'($urandom_range(0, 31)), 1);
      set_req(1, 1, 0, int'($urandom_range(0, 31)), 1);
      round(1'b0, 1'b0, -1);
    end

    // SPI busy: read wins, write waits, then write survives busy rising mid-burst
    rand_wd(0);
    set_req(0, 1, 1, 16, 3);
    set_req(1, 1, 0, 5, 2);
    round(1'b1, 1'b1, -1);
    set_req(1, 0, 0, 0, 0);
    round(1'b1, 1'b1, -1);
    round(1'b0, 1'b1, -1);

    // Empty burst
    set_req(0, 1, 1, 9, 0);
    round(1'b0, 1'b0, -1);

    // Reset on the third beat of an 8-byte write
    rand_wd(0);
    set_req(0, 1, 1, 10, 8);
    round(1'b0, 1'b0, 4);

    // After reset: tie goes to requester 0, then read back the partial write
    set_req(0, 1, 0, 2, 2);
    set_req(1, 1, 0, 20, 2);
    round(1'b0, 1'b0, -1);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 1, 0, 10, 8);
    round(1'b0, 1'b0, -1);

    // Random rounds
    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < 2; r++) begin
        set_req(r, $urandom_range(0, 3) != 0, bit'($urandom_range(0, 1)),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 40)));
        rand_wd(r);
      end
      round(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
